// File: rtl/timer_ctrl.sv
// Countdown timer controller: two-key BCD set/run/pause FSM with an expiry alarm.
// Ports: CLOCK_50, reset, tick, set_key, run_key, sw_val -> sec_bcd, min_bcd, state, running, alarm.
module timer_ctrl (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       tick,
    input  logic       set_key,
    input  logic       run_key,
    input  logic [7:0] sw_val,
    output logic [7:0] sec_bcd,
    output logic [7:0] min_bcd,
    output logic [2:0] state,
    output logic       running,
    output logic       alarm
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SET_SEC = 3'd1,
        SET_MIN = 3'd2,
        READY   = 3'd3,
        RUN     = 3'd4,
        PAUSE   = 3'd5,
        EXPIRED = 3'd6
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] sec_q, sec_d;
    logic [7:0] min_q, min_d;
    logic       alarm_q, alarm_d;
    logic       set_s1_q, set_s1_d, set_s2_q, set_s2_d;
    logic       run_s1_q, run_s1_d, run_s2_q, run_s2_d;
    logic       set_p, run_p;
    logic [15:0] cnt_dec;

    function automatic logic [7:0] clamp_sec(input logic [7:0] v);
        logic [3:0] t;
        logic [3:0] o;
        t = (v[7:4] > 4'd5) ? 4'd5 : v[7:4];
        o = (v[3:0] > 4'd9) ? 4'd9 : v[3:0];
        return {t, o};
    endfunction

    function automatic logic [7:0] clamp_min(input logic [7:0] v);
        logic [3:0] t;
        logic [3:0] o;
        t = (v[7:4] > 4'd9) ? 4'd9 : v[7:4];
        o = (v[3:0] > 4'd9) ? 4'd9 : v[3:0];
        return {t, o};
    endfunction

    // One-second BCD decrement of {min_tens, min_ones, sec_tens, sec_ones}.
    function automatic logic [15:0] dec_bcd(input logic [15:0] c);
        logic [3:0] m10, m1, s10, s1;
        {m10, m1, s10, s1} = c;
        if (s1 != 4'd0) begin
            s1 = s1 - 4'd1;
        end else begin
            s1 = 4'd9;
            if (s10 != 4'd0) begin
                s10 = s10 - 4'd1;
            end else begin
                s10 = 4'd5;
                if (m1 != 4'd0) begin
                    m1 = m1 - 4'd1;
                end else begin
                    m1  = 4'd9;
                    m10 = m10 - 4'd1;
                end
            end
        end
        return {m10, m1, s10, s1};
    endfunction

    // Press = registered 1->0 edge of the key sample.
    assign set_p   = set_s2_q & ~set_s1_q;
    assign run_p   = run_s2_q & ~run_s1_q;
    assign cnt_dec = dec_bcd({min_q, sec_q});

    always_comb begin
        set_s1_d = set_key;
        set_s2_d = set_s1_q;
        run_s1_d = run_key;
        run_s2_d = run_s1_q;
        state_d  = state_q;
        sec_d    = sec_q;
        min_d    = min_q;
        alarm_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (set_p) begin
                    sec_d   = clamp_sec(sw_val);
                    state_d = SET_SEC;
                end
            end
            SET_SEC: begin
                sec_d = clamp_sec(sw_val);
                if (set_p) state_d = SET_MIN;
            end
            SET_MIN: begin
                min_d = clamp_min(sw_val);
                if (set_p) state_d = READY;
            end
            READY: begin
                if (set_p) begin
                    sec_d   = clamp_sec(sw_val);
                    state_d = SET_SEC;
                end else if (run_p && {min_q, sec_q} != 16'h0000) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (run_p) state_d = PAUSE;
                // A tick in the same cycle as a pause still counts.
                if (tick) begin
                    {min_d, sec_d} = cnt_dec;
                    if ({min_q, sec_q} == 16'h0001) state_d = EXPIRED;
                end
            end
            PAUSE: begin
                if (set_p) begin
                    sec_d   = clamp_sec(sw_val);
                    state_d = SET_SEC;
                end else if (run_p) begin
                    state_d = RUN;
                end
            end
            EXPIRED: begin
                alarm_d = alarm_q ^ tick;
                if (set_p || run_p) begin
                    alarm_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q  <= IDLE;
            sec_q    <= 8'h00;
            min_q    <= 8'h00;
            alarm_q  <= 1'b0;
            set_s1_q <= 1'b1;
            set_s2_q <= 1'b1;
            run_s1_q <= 1'b1;
            run_s2_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            sec_q    <= sec_d;
            min_q    <= min_d;
            alarm_q  <= alarm_d;
            set_s1_q <= set_s1_d;
            set_s2_q <= set_s2_d;
            run_s1_q <= run_s1_d;
            run_s2_q <= run_s2_d;
        end
    end

    assign sec_bcd = sec_q;
    assign min_bcd = min_q;
    assign state   = state_q;
    assign running = (state_q == RUN);
    assign alarm   = alarm_q;

endmodule
